// File: rtl/pcm_arb_pkg.sv
// Shared types and constants for the PCM memory arbiter.
// Build option PCM_ARB_FIXED_PRIO_EN selects fixed priority in pcm_rr_arbiter.
package pcm_arb_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int CPU_ADDR_W = 20;

  typedef logic [1:0] grant_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  function automatic logic [NUM_PORTS-1:0] grant_onehot(input grant_idx_t idx);
    grant_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/pcm_rr_arbiter.sv
// Winner select for the four CPU ports: round-robin from a pointer by default,
// or fixed priority (port 0 highest) when PCM_ARB_FIXED_PRIO_EN is defined.
module pcm_rr_arbiter
  import pcm_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 grant_en,
  output logic                 any_req,
  output grant_idx_t           winner
);

  assign any_req = |req;

`ifdef PCM_ARB_FIXED_PRIO_EN

  logic unused_ctrl_s;
  assign unused_ctrl_s = clk ^ reset ^ grant_en;

  // Scan from lowest priority upward so the lowest set index wins last
  always_comb begin
    winner = 2'd0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      winner = req[i] ? grant_idx_t'(i) : winner;
    end
  end

`else

  grant_idx_t ptr_r;

  // Scan backwards from pointer+3 so the first set bit at/after the pointer wins
  always_comb begin
    winner = 2'd0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      winner = req[ptr_r + 2'(i)] ? grant_idx_t'(ptr_r + 2'(i)) : winner;
    end
  end

  // Pointer moves one past the winner on every grant
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= 2'd0;
    end else if (grant_en) begin
      ptr_r <= winner + 2'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

`endif

endmodule

// File: rtl/pcm_mem_arbiter.sv
// Four-port arbiter/sequencer in front of the PCM on-chip RAM slave port.
// Build option PCM_ARB_FIXED_PRIO_EN switches the arbiter to fixed priority.
module pcm_mem_arbiter
  import pcm_arb_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 2
)
(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_PORTS-1:0]                  cpu_valid,
  input  logic [NUM_PORTS-1:0]                  cpu_write,
  input  logic [NUM_PORTS-1:0][CPU_ADDR_W-1:0]  cpu_addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]      cpu_wdata,
  output logic [NUM_PORTS-1:0]                  cpu_done,
  output logic [DATA_W-1:0]                     cpu_rdata,
  output logic [ADDR_W-1:0]                     mem_address,
  output logic                                  mem_chipselect,
  output logic                                  mem_clken,
  output logic                                  mem_write,
  output logic [DATA_W-1:0]                     mem_writedata,
  output logic [1:0]                            mem_byteenable,
  input  logic [DATA_W-1:0]                     mem_readdata
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT);

  arb_state_t state_r;
  arb_state_t state_nxt_s;
  grant_idx_t grant_r;
  grant_idx_t winner_s;
  logic       write_r;
  logic [2:0] cnt_r;
  logic       any_req_s;
  logic       grant_en_s;
  logic       unused_addr_hi_s;

  assign mem_chipselect = 1'b1;
  assign mem_clken      = 1'b1;
  assign mem_byteenable = 2'b11;

  assign grant_en_s = (state_r == IDLE) && any_req_s;

  pcm_rr_arbiter u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (cpu_valid),
    .grant_en (grant_en_s),
    .any_req  (any_req_s),
    .winner   (winner_s)
  );

  // Address bits above the RAM window are deliberately dropped
  always_comb begin
    unused_addr_hi_s = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      unused_addr_hi_s = unused_addr_hi_s ^ (^cpu_addr[p][CPU_ADDR_W-1:ADDR_W]);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = any_req_s ? ISSUE : IDLE;
      ISSUE:   state_nxt_s = write_r ? DONE : WAIT_RD;
      WAIT_RD: state_nxt_s = (cnt_r == 3'd1) ? DONE : WAIT_RD;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Command latch, RAM drive and completion; mem_* are loaded at grant so they are valid in ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r       <= 2'd0;
      write_r       <= 1'b0;
      cnt_r         <= 3'd0;
      mem_address   <= {ADDR_W{1'b0}};
      mem_write     <= 1'b0;
      mem_writedata <= {DATA_W{1'b0}};
      cpu_done      <= {NUM_PORTS{1'b0}};
      cpu_rdata     <= {DATA_W{1'b0}};
    end else begin
      mem_write <= 1'b0;
      cpu_done  <= (state_nxt_s == DONE) ? grant_onehot(grant_r) : {NUM_PORTS{1'b0}};
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r       <= winner_s;
            write_r       <= cpu_write[winner_s];
            mem_address   <= cpu_addr[winner_s][ADDR_W-1:0];
            mem_writedata <= cpu_wdata[winner_s];
            mem_write     <= cpu_write[winner_s];
          end else begin
            grant_r <= grant_r;
          end
        end
        ISSUE: begin
          cnt_r <= LAT_INIT;
        end
        WAIT_RD: begin
          cnt_r <= cnt_r - 3'd1;
          if (cnt_r == 3'd1) begin
            cpu_rdata <= mem_readdata;
          end else begin
            cpu_rdata <= cpu_rdata;
          end
        end
        DONE: begin
          cnt_r <= 3'd0;
        end
        default: begin
          cnt_r <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/pcm_mem_arbiter.md
# pcm_mem_arbiter

Four-port round-robin arbiter and sequencer in front of the shared on-chip PCM memory-mapped RAM. Each CPU port issues one single-word read or write with a valid/done handshake. The block grants one port at a time, latches its command, and drives the RAM's Avalon-style slave port. It waits the RAM's fixed read latency and returns read data with a one-cycle done pulse to the granted port only.

## Interface
- `ADDR_W`, default 11: RAM word address width; low `ADDR_W` bits of the CPU address are used.
- `DATA_W`, default 16: data width.
- `READ_LAT`, default 2: RAM read latency in cycles; legal range 1..4.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `cpu_valid` in 4: per-port request.
- `cpu_write` in 4: per-port command; 1 = write, 0 = read.
- `cpu_addr` in 4x20: per-port address.
- `cpu_wdata` in 4xDATA_W: per-port write data.
- `cpu_done` out 4: one-hot, one-cycle completion pulse.
- `cpu_rdata` out DATA_W: read data, shared; valid while the matching `cpu_done` bit is high.
- `mem_address` out ADDR_W.
- `mem_chipselect` out 1.
- `mem_clken` out 1.
- `mem_write` out 1.
- `mem_writedata` out DATA_W.
- `mem_byteenable` out 2.
- `mem_readdata` in DATA_W.

## Operation
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE: if any `cpu_valid` bit is set, pick a winner, latch its write/addr/wdata and the grant index, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): drive `mem_address` and `mem_writedata` from the latched command; `mem_write` = latched write.
  - Write: next state DONE.
  - Read: next state WAIT_RD, with the latency counter loaded to `READ_LAT`.
- WAIT_RD: decrement the counter. When it reaches 1, register `mem_readdata` into `cpu_rdata` and go to DONE.
- DONE (1 cycle): `cpu_done[grant]` = 1; next state IDLE.
- Arbitration: round-robin over ports, starting the search at a pointer. On grant, the pointer becomes grant+1 (mod 4).
- Upper address bits `[19:ADDR_W]` are ignored; no error is signalled.
- Command fields are latched at grant. A requester only needs valid and fields stable until the cycle in which it is granted, and it must hold valid until done.
- On the edge where a requester samples `cpu_done` high, it either drops `cpu_valid` or presents a new request.
- Constant outputs: `mem_chipselect` = 1, `mem_clken` = 1, `mem_byteenable` = 2'b11.
- `cpu_rdata` holds its last value after DONE and is unchanged by writes.

## Timing
- Request sampled in IDLE at cycle 0; ISSUE is cycle 1.
- Write: `mem_write` high in cycle 1 only; `cpu_done` in cycle 2.
- Read: address valid from cycle 1. `mem_readdata` is sampled at the end of cycle 1+`READ_LAT`. `cpu_done` and `cpu_rdata` appear in cycle 2+`READ_LAT` (cycle 4 at default).
- Back-to-back: next IDLE grant one cycle after DONE. Write throughput is one every 3 cycles; read throughput is one every `READ_LAT`+3 cycles.
- Reset values: state IDLE, pointer 0, `cpu_done` 0, `cpu_rdata` 0, `mem_address` 0, `mem_write` 0, `mem_writedata` 0.
- Reset mid-operation: the transaction is aborted, no done pulse is issued, and `mem_write` is low in the next cycle.
- Simultaneous requests: the winner is the first set bit at or after the pointer.
- A single requester re-requesting is granted again only when no other port is valid.
- `cpu_valid` dropping after grant: the transaction still completes and done still pulses.

## Configuration
- `PCM_ARB_FIXED_PRIO_EN` defined: fixed priority is used. Port 0 is highest, port 3 lowest, and the pointer logic is removed.
- `PCM_ARB_FIXED_PRIO_EN` undefined: round-robin as specified above.

## Structure
- Package `pcm_arb_pkg`:
  - state enum `arb_state_t` (IDLE, ISSUE, WAIT_RD, DONE).
  - `NUM_PORTS` = 4.
  - `CPU_ADDR_W` = 20.
  - grant index type (2 bits).
- Sub-module `pcm_rr_arbiter`: combinational winner select from request vector and pointer, plus registered pointer update on grant. It also houses the fixed-priority variant under the macro.

## Test plan
- After reset, port 2 writes 0xBEEF to address 0x00005 → `mem_write`=1, `mem_address`=0x005, `mem_writedata`=0xBEEF in cycle 1; `cpu_done`=4'b0100 in cycle 2.
- Port 1 reads address 0x00005 with the RAM returning 0xBEEF, default `READ_LAT` → `cpu_done`=4'b0010 and `cpu_rdata`=0xBEEF at cycle 4; `mem_write` stays 0 throughout.
- All four ports valid from reset and held → grants in order 0,1,2,3; then 0 again with a round-robin pointer, with done pulses 3 cycles apart for writes.
- Port 0 re-requests immediately while port 3 is waiting → port 3 is granted before port 0. With `PCM_ARB_FIXED_PRIO_EN`, port 0 wins instead.
- Address 0xFFFFF → `mem_address`=0x7FF.
- Reset asserted during WAIT_RD → no `cpu_done` pulse, state IDLE, `cpu_rdata`=0, and the next grant goes to port 0.
